rgb_to_yuv_conversion: RTL and testbench

//  Compression-side colour-space stage; the inverse of the decompressor's YUV->RGB conversion.

---
 rtl/rgb_to_yuv_conversion_pkg.sv | 43 ++++
 rtl/rgb_to_yuv_conversion_pixel.sv | 34 +++
 rtl/rgb_to_yuv_conversion.sv | 155 +++++++++++++++
 tb/tb_rgb_to_yuv_conversion.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_yuv_conversion_pkg.sv
// Shared types, BT.601 integer coefficients and the byte clamp used by
// the RGB->YUV colour-space stage.
package rgb_to_yuv_conversion_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_CAP,
    S_CALC,
    S_WY,
    S_WU,
    S_WV,
    S_DONE
  } state_t;

  localparam logic signed [17:0] C_YR   = 18'sd66;
  localparam logic signed [17:0] C_YG   = 18'sd129;
  localparam logic signed [17:0] C_YB   = 18'sd25;
  localparam logic signed [17:0] C_UR   = -18'sd38;
  localparam logic signed [17:0] C_UG   = -18'sd74;
  localparam logic signed [17:0] C_UB   = 18'sd112;
  localparam logic signed [17:0] C_VR   = 18'sd112;
  localparam logic signed [17:0] C_VG   = -18'sd94;
  localparam logic signed [17:0] C_VB   = -18'sd18;
  localparam logic signed [17:0] ROUND  = 18'sd128;
  localparam logic signed [17:0] Y_OFF  = 18'sd16;
  localparam logic signed [17:0] UV_OFF = 18'sd128;

  function automatic logic [7:0] clamp_u8(input logic signed [17:0] v);
    logic [7:0] res;
    if (v < 18'sd0) begin
      res = 8'd0;
    end else if (v > 18'sd255) begin
      res = 8'd255;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_to_yuv_conversion_pixel.sv
// Combinational single-pixel R,G,B -> Y,U,V (BT.601 integer form) with
// floor shift and clamp to 0..255.
module rgb_to_yuv_conversion_pixel
  import rgb_to_yuv_conversion_pkg::*;
(
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_y,
  output logic [7:0] o_u,
  output logic [7:0] o_v
);

  logic signed [17:0] w_r;
  logic signed [17:0] w_g;
  logic signed [17:0] w_b;
  logic signed [17:0] w_y_sum;
  logic signed [17:0] w_u_sum;
  logic signed [17:0] w_v_sum;

  assign w_r = $signed({10'd0, i_r});
  assign w_g = $signed({10'd0, i_g});
  assign w_b = $signed({10'd0, i_b});

  assign w_y_sum = C_YR * w_r + C_YG * w_g + C_YB * w_b + ROUND;
  assign w_u_sum = C_UR * w_r + C_UG * w_g + C_UB * w_b + ROUND;
  assign w_v_sum = C_VR * w_r + C_VG * w_g + C_VB * w_b + ROUND;

  // Arithmetic shift keeps floor semantics for the negative chroma sums.
  assign o_y = clamp_u8((w_y_sum >>> 8) + Y_OFF);
  assign o_u = clamp_u8((w_u_sum >>> 8) + UV_OFF);
  assign o_v = clamp_u8((w_v_sum >>> 8) + UV_OFF);

endmodule

// File: rtl/rgb_to_yuv_conversion.sv
// Reads a packed 24-bit RGB frame from SRAM two pixels at a time and writes
// separate Y, U and V planes; 8 cycles per pixel pair, start/done handshake.
module rgb_to_yuv_conversion
  import rgb_to_yuv_conversion_pkg::*;
#(
  parameter int AW              = 18,
  parameter int DW              = 16,
  parameter int W               = 320,
  parameter int H               = 240,
  parameter int READ_ADDR_BASE  = 115200,
  parameter int WRITE_ADDR_BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  output logic          o_done,
  output logic [AW-1:0] o_raddr,
  input  logic [DW-1:0] i_rdata,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_wr_enable
);

  localparam logic [AW-1:0] LAST_PAIR = AW'(W * H / 2 - 1);
  localparam logic [AW-1:0] RB        = AW'(READ_ADDR_BASE);
  localparam logic [AW-1:0] YB        = AW'(WRITE_ADDR_BASE);
  localparam logic [AW-1:0] UB        = AW'(WRITE_ADDR_BASE + W * H / 2);
  localparam logic [AW-1:0] VB        = AW'(WRITE_ADDR_BASE + W * H);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pair;
  logic [DW-1:0] r_w0;
  logic [DW-1:0] r_w1;
  logic [DW-1:0] r_w2;
  logic [DW-1:0] r_u;
  logic [DW-1:0] r_v;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic [AW-1:0] w_rd_addr;

  logic [7:0] w_r [2];
  logic [7:0] w_g [2];
  logic [7:0] w_b [2];
  logic [7:0] w_y [2];
  logic [7:0] w_u [2];
  logic [7:0] w_v [2];

  // Pair p starts at RB + 3p; shift-add keeps the product in AW bits.
  assign w_rd_addr = RB + r_pair + (r_pair << 1);

  // Word layout: {R0,G0} {B0,R1} {G1,B1}, earlier component in the upper byte.
  assign w_r[0] = r_w0[15:8];
  assign w_g[0] = r_w0[7:0];
  assign w_b[0] = r_w1[15:8];
  assign w_r[1] = r_w1[7:0];
  assign w_g[1] = r_w2[15:8];
  assign w_b[1] = r_w2[7:0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_pix
    rgb_to_yuv_conversion_pixel u_pix (
      .i_r (w_r[gi]),
      .i_g (w_g[gi]),
      .i_b (w_b[gi]),
      .o_y (w_y[gi]),
      .o_u (w_u[gi]),
      .o_v (w_v[gi])
    );
  end

  always_comb begin
    w_next      = r_state;
    o_raddr     = '0;
    o_wr_enable = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RD0;
      S_RD0: begin
        o_raddr = w_rd_addr;
        w_next  = S_RD1;
      end
      S_RD1: begin
        o_raddr = w_rd_addr + AW'(1);
        w_next  = S_RD2;
      end
      S_RD2: begin
        o_raddr = w_rd_addr + AW'(2);
        w_next  = S_CAP;
      end
      S_CAP:  w_next = S_CALC;
      S_CALC: w_next = S_WY;
      S_WY: begin
        o_wr_enable = 1'b1;
        w_next      = S_WU;
      end
      S_WU: begin
        o_wr_enable = 1'b1;
        w_next      = S_WV;
      end
      S_WV: begin
        o_wr_enable = 1'b1;
        w_next      = (r_pair == LAST_PAIR) ? S_DONE : S_RD0;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Write address/data are loaded one state ahead so they are valid in the
  // strobe cycle and simply hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pair  <= '0;
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_u     <= '0;
      r_v     <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_RD1: r_w0 <= i_rdata;
        S_RD2: r_w1 <= i_rdata;
        S_CAP: r_w2 <= i_rdata;
        S_CALC: begin
          r_waddr <= YB + r_pair;
          r_wdata <= {w_y[0], w_y[1]};
          r_u     <= {w_u[0], w_u[1]};
          r_v     <= {w_v[0], w_v[1]};
        end
        S_WY: begin
          r_waddr <= UB + r_pair;
          r_wdata <= r_u;
        end
        S_WU: begin
          r_waddr <= VB + r_pair;
          r_wdata <= r_v;
        end
        S_WV: if (r_pair != LAST_PAIR) r_pair <= r_pair + AW'(1);
        S_DONE: r_pair <= '0;
        default: ;
      endcase
    end
  end

  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: tb/tb_rgb_to_yuv_conversion.sv
// Self-checking bench: 4x2 frame against an arithmetic BT.601 reference,
// covering latency, start filtering, back-to-back frames and mid-frame reset.
module tb_rgb_to_yuv_conversion;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H / 2;
  localparam int RB = 100;
  localparam int WB = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic          o_done;
  logic [AW-1:0] o_raddr;
  logic [DW-1:0] i_rdata;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_wr_enable;

  logic [15:0]   mem [0:255];
  logic [AW-1:0] wr_addr_q [$];
  logic [15:0]   wr_data_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_done   = 0;

  rgb_to_yuv_conversion #(
    .AW              (AW),
    .DW              (DW),
    .W               (W),
    .H               (H),
    .READ_ADDR_BASE  (RB),
    .WRITE_ADDR_BASE (WB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .o_done      (o_done),
    .o_raddr     (o_raddr),
    .i_rdata     (i_rdata),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_wr_enable (o_wr_enable)
  );

  always #5 clk = ~clk;

  // SRAM model: read data valid the cycle after the address.
  always @(posedge clk) i_rdata <= mem[o_raddr];

  always @(negedge clk) begin
    if (o_wr_enable === 1'b1) begin
      wr_addr_q.push_back(o_waddr);
      wr_data_q.push_back(o_wdata);
      $display("%0t write addr=%0d data=%h", $time, o_waddr, o_wdata);
    end
    if (o_done === 1'b1) begin
      n_done++;
      $display("%0t done", $time);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Reference: {Y,U,V} for one pixel straight from the BT.601 integer rules.
  function automatic logic [23:0] to_yuv(input int r, input int g, input int b);
    int y, u, v;
    y = 16  + ((66 * r + 129 * g + 25 * b + 128) >>> 8);
    u = 128 + ((-38 * r - 74 * g + 112 * b + 128) >>> 8);
    v = 128 + ((112 * r - 94 * g - 18 * b + 128) >>> 8);
    return {clamp8(y), clamp8(u), clamp8(v)};
  endfunction

  task automatic load_frame(input bit directed);
    for (int i = 0; i < 3 * N; i++) mem[RB + i] = 16'($urandom);
    if (directed) begin
      mem[RB + 0] = 16'h0000;
      mem[RB + 1] = 16'h00FF;
      mem[RB + 2] = 16'hFFFF;
      mem[RB + 3] = 16'hFF00;
      mem[RB + 4] = 16'h0000;
      mem[RB + 5] = 16'h00FF;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Called in the first RD0 cycle; returns cycles from the start cycle to done.
  task automatic wait_done(input bit noise, output int lat);
    int cyc;
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 8 * N + 20) begin
      i_start = noise && (cyc == 3 || cyc == 20);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    lat = cyc;
  endtask

  task automatic check_frame(input string tag, input int lat, input int done_before);
    logic [15:0] w0, w1, w2;
    logic [23:0] p0, p1;
    int          ea [3];
    logic [15:0] ed [3];
    int          idx;
    #1;
    check({tag, " latency"}, lat, 8 * N + 1);
    check({tag, " done_pulses"}, n_done - done_before, 1);
    check({tag, " n_writes"}, wr_addr_q.size(), 3 * N);
    for (int p = 0; p < N; p++) begin
      w0 = mem[RB + 3 * p];
      w1 = mem[RB + 3 * p + 1];
      w2 = mem[RB + 3 * p + 2];
      p0 = to_yuv(int'(w0[15:8]), int'(w0[7:0]), int'(w1[15:8]));
      p1 = to_yuv(int'(w1[7:0]), int'(w2[15:8]), int'(w2[7:0]));
      ea = '{WB + p, WB + N + p, WB + 2 * N + p};
      ed = '{{p0[23:16], p1[23:16]}, {p0[15:8], p1[15:8]}, {p0[7:0], p1[7:0]}};
      for (int k = 0; k < 3; k++) begin
        idx = 3 * p + k;
        if (idx < wr_addr_q.size()) begin
          check($sformatf("%s p%0d plane%0d addr", tag, p, k), wr_addr_q[idx], ea[k]);
          check($sformatf("%s p%0d plane%0d data", tag, p, k), wr_data_q[idx], ed[k]);
        end
      end
    end
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    int lat, d0, cyc, nw;
    rst_n   = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset raddr", o_raddr, 0);
    check("reset waddr", o_waddr, 0);
    check("reset wdata", o_wdata, 0);
    check("reset wr_enable", o_wr_enable, 0);
    check("reset done", o_done, 0);
    rst_n = 1'b1;

    // Black/white then red/blue pairs, remaining pairs random.
    load_frame(1'b1);
    d0 = n_done;
    pulse_start();
    wait_done(1'b0, lat);
    check("black_white Y", wr_data_q[0], 16'h10EB);
    check("black_white U", wr_data_q[1], 16'h8080);
    check("black_white V", wr_data_q[2], 16'h8080);
    check("red_blue Y", wr_data_q[3], 16'h5229);
    check("red_blue U", wr_data_q[4], 16'h5AF0);
    check("red_blue V", wr_data_q[5], 16'hF06E);
    check_frame("directed", lat, d0);
    @(negedge clk);
    check("idle done", o_done, 0);
    check("idle raddr", o_raddr, 0);
    check("idle wr_enable", o_wr_enable, 0);
    check("idle waddr hold", o_waddr, WB + 3 * N - 1);

    // Stray starts mid-frame and in DONE are ignored; start in the next IDLE cycle runs again.
    load_frame(1'b0);
    d0 = n_done;
    pulse_start();
    wait_done(1'b1, lat);
    check_frame("noisy_start", lat, d0);
    d0 = n_done;
    i_start = 1'b1;
    @(negedge clk);
    check("start in DONE ignored", o_raddr, 0);
    @(negedge clk);
    i_start = 1'b0;
    wait_done(1'b0, lat);
    check_frame("back_to_back", lat, d0);

    // Asynchronous reset during WU of pair 1.
    load_frame(1'b0);
    pulse_start();
    cyc = 1;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    check("WU pair1 wr_enable", o_wr_enable, 1);
    check("WU pair1 waddr", o_waddr, WB + N + 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset raddr", o_raddr, 0);
    check("async reset waddr", o_waddr, 0);
    check("async reset wdata", o_wdata, 0);
    check("async reset wr_enable", o_wr_enable, 0);
    check("async reset done", o_done, 0);
    nw = wr_addr_q.size();
    repeat (3) @(negedge clk);
    check("no writes in reset", wr_addr_q.size(), nw);
    rst_n = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    load_frame(1'b0);
    d0 = n_done;
    pulse_start();
    wait_done(1'b0, lat);
    check_frame("after_reset", lat, d0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
